cpu_ret_stack: RTL and testbench
================================

CPU_RET_STACK -- requirements
Module: cpu_ret_stack

Interface
REQ-001 Parameter WIDTH, default 8, address width; matches the jump unit's address width.
REQ-002 Parameter DEPTH, default 8, number of return-address entries; power of two, 2 to 64.
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 CALL  input  1  push request, sampled at rising CLK.
REQ-006 RET  input  1  pop request, sampled at rising CLK.
REQ-007 RET_ADDR_IN  input  WIDTH  return address to push, normally PC+1 of the CALL instruction.
REQ-008 CLR_ERR  input  1  synchronous clear of the sticky error flags.
REQ-009 LR_ADDRESS  output  WIDTH  current top-of-stack entry, feeding the jump unit's CALL/return base.
REQ-010 EMPTY  output  1  high when the entry count is 0.
REQ-011 FULL  output  1  high when the entry count equals DEPTH.
REQ-012 COUNT  output  clog2(DEPTH)+1  number of valid entries.
REQ-013 OVERFLOW  output  1  sticky; a push occurred while FULL.
REQ-014 UNDERFLOW  output  1  sticky; a pop occurred while EMPTY.

Function
REQ-015 The block SHALL be a circular LIFO of DEPTH entries, addressed by a top pointer SP (clog2(DEPTH) bits) and a count CNT (0..DEPTH).
REQ-016 The block SHALL drive LR_ADDRESS combinationally from entry[SP-1 mod DEPTH] when CNT>0, and drive 0 when CNT=0.
REQ-017 CALL only, CNT<DEPTH: write RET_ADDR_IN to entry[SP], SP<=SP+1 mod DEPTH, CNT<=CNT+1; new value is visible on LR_ADDRESS in the cycle after the edge.
REQ-018 CALL only, CNT=DEPTH: write entry[SP] (overwriting the oldest entry), SP<=SP+1 mod DEPTH, CNT stays at DEPTH, and OVERFLOW<=1.
REQ-019 RET only, CNT>0: SP<=SP-1 mod DEPTH, CNT<=CNT-1; entry contents are unchanged.
REQ-020 RET only, CNT=0: SP and CNT unchanged, UNDERFLOW<=1, and LR_ADDRESS stays 0.
REQ-021 CALL and RET together, CNT>0: overwrite entry[SP-1] with RET_ADDR_IN; SP and CNT unchanged; no flag change, including when FULL.
REQ-022 CALL and RET together, CNT=0: behave as a CALL alone (REQ-017) and set UNDERFLOW<=1.
REQ-023 Neither CALL nor RET: no state change.
REQ-024 EMPTY = (CNT==0) and FULL = (CNT==DEPTH), decoded combinationally from CNT.
REQ-025 Once set, OVERFLOW and UNDERFLOW SHALL hold until CLR_ERR or RST.
REQ-026 CLR_ERR clears both flags at the edge; a new error event in the same cycle takes priority and leaves its flag set.
REQ-027 Pointer and count arithmetic SHALL wrap modulo DEPTH for SP only; CNT saturates at 0 and DEPTH and never wraps.
REQ-028 The block SHALL add no latency beyond one edge: any request sampled at edge N is fully reflected on all outputs after edge N.

Reset
REQ-029 RST high SHALL immediately, without a clock, force SP=0, CNT=0, OVERFLOW=0, UNDERFLOW=0, and all entries to 0.
REQ-030 While RST is high, outputs SHALL read LR_ADDRESS=0, EMPTY=1, FULL=0, COUNT=0, and CALL/RET SHALL be ignored.
REQ-031 RST asserted in mid-operation (for example CNT=5) SHALL discard all entries; the first CALL after release pushes into entry 0.

Verification
REQ-032 Reset, then CALL with 0x10, 0x20, 0x30 in three cycles -> LR_ADDRESS 0x10, 0x20, 0x30, COUNT=3; then RET x3 -> LR_ADDRESS 0x20, 0x10, 0, EMPTY=1.
REQ-033 DEPTH=4: CALL 0x01..0x05 -> FULL=1, OVERFLOW=1, COUNT=4, LR_ADDRESS=0x05; RET x4 -> LR_ADDRESS 0x04, 0x03, 0x02, then 0 with EMPTY=1 (0x01 is lost).
REQ-034 Reset, then RET -> UNDERFLOW=1, COUNT=0, LR_ADDRESS=0; then CLR_ERR -> UNDERFLOW=0; then CLR_ERR and RET in the same cycle -> UNDERFLOW stays 1.
REQ-035 CALL 0x40, then CALL and RET together with 0x55 -> COUNT=1, LR_ADDRESS=0x55; with the stack empty, CALL and RET together with 0x66 -> COUNT=1, LR_ADDRESS=0x66, UNDERFLOW=1.
REQ-036 CALL 0xA1, 0xA2, then assert RST asynchronously between clock edges -> outputs are zero and EMPTY=1 before the next edge; after release, CALL 0xB0 -> LR_ADDRESS=0xB0, COUNT=1.

Source files
------------

// File: rtl/cpu_ret_stack.sv
// Circular return-address stack for the jump unit.
// When a push happens while the stack is full, it overwrites the oldest entry instead of stalling.
module cpu_ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_call,
  input  logic                       i_ret,
  input  logic [WIDTH-1:0]           i_ret_addr_in,
  input  logic                       i_clr_err,
  output logic [WIDTH-1:0]           o_lr_address,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] SP_ONE   = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_sp;
  logic [CW-1:0]    r_cnt;
  logic             r_overflow;
  logic             r_underflow;

  logic [PW-1:0]    w_top;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_replace;
  logic             w_ovf_evt;
  logic             w_unf_evt;

  assign w_top   = r_sp - SP_ONE;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_FULL);

  // A simultaneous call+return on an empty stack degrades to a plain push.
  assign w_push    = i_call & (~i_ret | w_empty);
  assign w_pop     = i_ret & ~i_call & ~w_empty;
  assign w_replace = i_call & i_ret & ~w_empty;
  assign w_ovf_evt = i_call & ~i_ret & w_full;
  assign w_unf_evt = i_ret & w_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_sp] <= i_ret_addr_in;
    end else if (w_replace) begin
      r_mem[w_top] <= i_ret_addr_in;
    end
  end

  // SP wraps freely, while CNT saturates at DEPTH so that it stays a true occupancy count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sp  <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + SP_ONE;
      if (!w_full) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else if (w_pop) begin
      r_sp  <= w_top;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // If an error happens in the same cycle as a clear, the error wins and the flag stays set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (i_clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_evt) begin
        r_underflow <= 1'b1;
      end else if (i_clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign o_lr_address = w_empty ? '0 : r_mem[w_top];
  assign o_empty      = w_empty;
  assign o_full       = w_full;
  assign o_count      = r_cnt;
  assign o_overflow   = r_overflow;
  assign o_underflow  = r_underflow;

endmodule

// File: tb/tb_cpu_ret_stack.sv
// Directed, table-driven bench for cpu_ret_stack.
// It exercises the default DEPTH=8 instance and a DEPTH=4 instance, which is used for the wrap-around cases.
module tb_cpu_ret_stack;

  typedef struct {
    logic       call;
    logic       ret;
    logic       clr;
    logic [7:0] addr;
    logic [7:0] lr;
    logic [3:0] cnt;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       unf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       call8 = 1'b0, ret8 = 1'b0, clr8 = 1'b0;
  logic [7:0] addr8 = '0;
  logic [7:0] lr8;
  logic       empty8, full8, ovf8, unf8;
  logic [3:0] cnt8;

  logic       call4 = 1'b0, ret4 = 1'b0, clr4 = 1'b0;
  logic [7:0] addr4 = '0;
  logic [7:0] lr4;
  logic       empty4, full4, ovf4, unf4;
  logic [2:0] cnt4;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  cpu_ret_stack #(.WIDTH(8), .DEPTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_call(call8), .i_ret(ret8),
    .i_ret_addr_in(addr8), .i_clr_err(clr8), .o_lr_address(lr8),
    .o_empty(empty8), .o_full(full8), .o_count(cnt8),
    .o_overflow(ovf8), .o_underflow(unf8)
  );

  cpu_ret_stack #(.WIDTH(8), .DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_call(call4), .i_ret(ret4),
    .i_ret_addr_in(addr4), .i_clr_err(clr4), .o_lr_address(lr4),
    .o_empty(empty4), .o_full(full4), .o_count(cnt4),
    .o_overflow(ovf4), .o_underflow(unf4)
  );

  function automatic vec_t mk(input logic c, input logic r, input logic cl,
                              input logic [7:0] a, input logic [7:0] lr,
                              input logic [3:0] cnt, input logic ovf, input logic unf);
    vec_t v;
    v.call = c; v.ret = r; v.clr = cl; v.addr = a;
    v.lr = lr; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    v.empty = (cnt == 4'd0);
    v.full  = (cnt == 4'd8);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic r, input logic cl, input logic [7:0] a);
    call8 = c; ret8 = r; clr8 = cl; addr8 = a;
    @(posedge clk);
    #1;
    call8 = 1'b0; ret8 = 1'b0; clr8 = 1'b0; addr8 = '0;
  endtask

  task automatic applyStimulus4(input logic c, input logic r, input logic [7:0] a);
    call4 = c; ret4 = r; clr4 = 1'b0; addr4 = a;
    @(posedge clk);
    #1;
    call4 = 1'b0; ret4 = 1'b0; addr4 = '0;
  endtask

  task automatic checkAll8(input string tag, input logic [7:0] lr, input logic [3:0] cnt,
                           input logic empty, input logic full, input logic ovf, input logic unf);
    checkOutput({tag, ".lr"},    32'(lr8),    32'(lr));
    checkOutput({tag, ".cnt"},   32'(cnt8),   32'(cnt));
    checkOutput({tag, ".empty"}, 32'(empty8), 32'(empty));
    checkOutput({tag, ".full"},  32'(full8),  32'(full));
    checkOutput({tag, ".ovf"},   32'(ovf8),   32'(ovf));
    checkOutput({tag, ".unf"},   32'(unf8),   32'(unf));
  endtask

  initial begin
    // Push/pop ordering, underflow with clears, call+ret replacement, filling to full, and overflow with a same-cycle clear.
    vecs.push_back(mk(1, 0, 0, 8'h10, 8'h10, 4'd1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h20, 8'h20, 4'd2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h30, 8'h30, 4'd3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h20, 4'd2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h10, 4'd1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 8'h00, 4'd0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h40, 8'h40, 4'd1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h55, 8'h55, 4'd1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h00, 4'd0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h66, 8'h66, 4'd1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h66, 4'd1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 8'hFF, 8'h66, 4'd1, 0, 0));
    for (int i = 0; i < 7; i++) begin
      vecs.push_back(mk(1, 0, 0, 8'(8'h71 + i), 8'(8'h71 + i), 4'(i + 2), 0, 0));
    end
    vecs.push_back(mk(1, 1, 0, 8'h99, 8'h99, 4'd8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h9A, 8'h9A, 4'd8, 1, 0));
    vecs.push_back(mk(1, 0, 1, 8'h9B, 8'h9B, 4'd8, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 8'h9B, 4'd8, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 8'h9A, 4'd7, 0, 0));

    rst = 1'b1;
    #12;
    checkAll8("reset", 8'h00, 4'd0, 1, 0, 0, 0);
    checkOutput("reset4.empty", 32'(empty4), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].call, vecs[i].ret, vecs[i].clr, vecs[i].addr);
      checkAll8($sformatf("vec%0d", i), vecs[i].lr, vecs[i].cnt, vecs[i].empty,
                vecs[i].full, vecs[i].ovf, vecs[i].unf);
    end

    // Assert reset asynchronously in the middle of operation, check that requests are ignored while it is held, then push into the fresh stack.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 0, 8'hA1);
    applyStimulus(1, 0, 0, 8'hA2);
    checkAll8("preRst", 8'hA2, 4'd2, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkAll8("asyncRst", 8'h00, 4'd0, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 8'hEE);
    applyStimulus(0, 1, 0, 8'h00);
    checkAll8("rstHeld", 8'h00, 4'd0, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 0, 8'hB0);
    checkAll8("postRst", 8'hB0, 4'd1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 8'h00);
    checkAll8("postRstPop", 8'h00, 4'd0, 1, 0, 0, 0);

    // On the DEPTH=4 instance, five pushes overwrite the oldest entry (0x01), so it is never returned.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus4(1, 0, 8'(i));
      checkOutput($sformatf("d4push%0d.lr", i),  32'(lr4),   32'(i));
      checkOutput($sformatf("d4push%0d.cnt", i), 32'(cnt4),  32'((i > 4) ? 4 : i));
      checkOutput($sformatf("d4push%0d.full", i), 32'(full4), 32'(i >= 4));
      checkOutput($sformatf("d4push%0d.ovf", i),  32'(ovf4),  32'(i == 5));
    end
    begin
      logic [7:0] expLr [4];
      expLr[0] = 8'h04; expLr[1] = 8'h03; expLr[2] = 8'h02; expLr[3] = 8'h00;
      for (int i = 0; i < 4; i++) begin
        applyStimulus4(0, 1, 8'h00);
        checkOutput($sformatf("d4pop%0d.lr", i),  32'(lr4),  32'(expLr[i]));
        checkOutput($sformatf("d4pop%0d.cnt", i), 32'(cnt4), 32'(3 - i));
      end
    end
    checkOutput("d4.empty", 32'(empty4), 32'd1);
    checkOutput("d4.unf",   32'(unf4),   32'd0);
    checkOutput("d4.ovfSticky", 32'(ovf4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
